// File: rtl/breakdown_classifier_if.sv
// Bundle of per-channel control, ADC sample bus and classifier outputs.
// master drives arm/clear/samples; slave is the classifier.
interface breakdown_classifier_if #(
  parameter int N_CH  = 2,
  parameter int DW    = 16,
  parameter int CNT_W = 16
);
  logic [N_CH-1:0]       arm;
  logic [N_CH-1:0]       clear;
  logic                  sample_valid;
  logic [N_CH*DW-1:0]    sample_voltage;
  logic [N_CH*DW-1:0]    sample_current;
  logic [N_CH-1:0]       is_breakdown;
  logic [N_CH-1:0]       is_short;
  logic [N_CH-1:0]       is_open;
  logic [N_CH-1:0]       event_pulse;
  logic [N_CH*CNT_W-1:0] ign_delay;
  logic [N_CH-1:0]       busy;

  modport master (
    output arm,
    output clear,
    output sample_valid,
    output sample_voltage,
    output sample_current,
    input  is_breakdown,
    input  is_short,
    input  is_open,
    input  event_pulse,
    input  ign_delay,
    input  busy
  );

  modport slave (
    input  arm,
    input  clear,
    input  sample_valid,
    input  sample_voltage,
    input  sample_current,
    output is_breakdown,
    output is_short,
    output is_open,
    output event_pulse,
    output ign_delay,
    output busy
  );
endinterface

// File: rtl/breakdown_classifier.sv
// Multi-channel gap-state classifier: hold-off, filtered
// breakdown/short detection, open timeout, ignition delay.
module breakdown_classifier #(
  parameter int N_CH = 2,
  parameter int DW = 16,
  parameter int CNT_W = 16,
  parameter logic signed [DW-1:0] V_LO = 16'sd8,
  parameter logic signed [DW-1:0] V_HI = 16'sd35,
  parameter logic signed [DW-1:0] I_BRK = 16'sd10,
  parameter logic signed [DW-1:0] I_SHORT = 16'sd40,
  parameter bit CUR_EN = 1'b0,
  parameter int unsigned FILT_N = 10,
  parameter int unsigned HOLDOFF_CYC = 100000000,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic clk,
  input logic rst,
  breakdown_classifier_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLDOFF,
    S_WATCH,
    S_BRK,
    S_SHORT,
    S_OPEN
  } state_t;

  localparam logic [31:0] HOLD_LAST = HOLDOFF_CYC - 1;
  localparam logic [31:0] TO_LAST = TIMEOUT_CYC - 1;
  localparam logic [CNT_W-1:0] FILT_C = CNT_W'(FILT_N);
  localparam logic [CNT_W-1:0] FILT_M1 = CNT_W'(FILT_N - 1);
  localparam logic [31:0] IGN_MAX =
    32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CNT_W-1:0] IGN_SAT = CNT_W'(IGN_MAX);

  logic [N_CH-1:0] brk_v;
  logic [N_CH-1:0] sht_v;
  logic [N_CH-1:0] opn_v;
  logic [N_CH-1:0] ev_v;
  logic [N_CH-1:0] busy_v;
  logic [N_CH*CNT_W-1:0] ign_v;

  assign bus.is_breakdown = brk_v;
  assign bus.is_short = sht_v;
  assign bus.is_open = opn_v;
  assign bus.event_pulse = ev_v;
  assign bus.busy = busy_v;
  assign bus.ign_delay = ign_v;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    state_t st_q;
    state_t st_d;
    logic [31:0] hcnt_q;
    logic [31:0] wcnt_q;
    logic [CNT_W-1:0] bcnt_q;
    logic [CNT_W-1:0] scnt_q;
    logic [CNT_W-1:0] ign_q;
    logic [CNT_W-1:0] ign_val;
    logic brk_q;
    logic sht_q;
    logic opn_q;
    logic ev_q;
    logic busy_q;
    logic signed [DW-1:0] v;
    logic signed [DW-1:0] i;
    logic is_b;
    logic is_s;
    logic smp;
    logic b_hit;
    logic s_hit;
    logic t_hit;
    logic to_term;
    logic to_arm;

    assign v = $signed(bus.sample_voltage[k*DW +: DW]);
    assign i = $signed(bus.sample_current[k*DW +: DW]);

    assign is_s = (v < V_LO) && (i >= I_SHORT);
    assign is_b = (v >= V_LO) && (v <= V_HI) &&
                  (!CUR_EN || (i >= I_BRK));

    assign smp = (st_q == S_WATCH) && bus.sample_valid;
    assign b_hit = smp && is_b && (bcnt_q == FILT_M1);
    assign s_hit = smp && is_s && (scnt_q == FILT_M1);
    assign t_hit = (TIMEOUT_CYC != 0) &&
                   (wcnt_q == TO_LAST);

    // Count includes the cycle on which breakdown is seen.
    assign ign_val = (wcnt_q >= IGN_MAX) ? IGN_SAT :
                     wcnt_q[CNT_W-1:0] + CNT_W'(1);

    always_comb begin
      st_d = st_q;
      if (bus.clear[k]) begin
        st_d = S_IDLE;
      end else begin
        unique case (st_q)
          S_IDLE: begin
            if (bus.arm[k])
              st_d = (HOLDOFF_CYC == 0) ? S_WATCH : S_HOLDOFF;
          end
          S_HOLDOFF: begin
            if (!bus.arm[k])
              st_d = S_IDLE;
            else if (hcnt_q == HOLD_LAST)
              st_d = S_WATCH;
          end
          S_WATCH: begin
            if (!bus.arm[k])
              st_d = S_IDLE;
            else if (b_hit)
              st_d = S_BRK;
            else if (s_hit)
              st_d = S_SHORT;
            else if (t_hit)
              st_d = S_OPEN;
          end
          default: st_d = st_q;
        endcase
      end
    end

    assign to_term = (st_q == S_WATCH) &&
                     ((st_d == S_BRK) ||
                      (st_d == S_SHORT) ||
                      (st_d == S_OPEN));
    assign to_arm = (st_q == S_IDLE) && (st_d != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q <= S_IDLE;
      end else begin
        st_q <= st_d;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hcnt_q <= '0;
        wcnt_q <= '0;
        bcnt_q <= '0;
        scnt_q <= '0;
        ign_q <= '0;
        brk_q <= 1'b0;
        sht_q <= 1'b0;
        opn_q <= 1'b0;
        ev_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        ev_q <= to_term;
        brk_q <= (st_d == S_BRK);
        sht_q <= (st_d == S_SHORT);
        opn_q <= (st_d == S_OPEN);
        busy_q <= (st_d == S_HOLDOFF) ||
                  (st_d == S_WATCH);

        if (st_q == S_HOLDOFF)
          hcnt_q <= hcnt_q + 32'd1;
        else
          hcnt_q <= '0;

        if (st_q != S_WATCH)
          wcnt_q <= '0;
        else if (wcnt_q != '1)
          wcnt_q <= wcnt_q + 32'd1;

        // Filters restart from zero on every fresh WATCH.
        if (st_q != S_WATCH) begin
          bcnt_q <= '0;
          scnt_q <= '0;
        end else if (bus.sample_valid) begin
          if (!is_b)
            bcnt_q <= '0;
          else if (bcnt_q != FILT_C)
            bcnt_q <= bcnt_q + CNT_W'(1);
          if (!is_s)
            scnt_q <= '0;
          else if (scnt_q != FILT_C)
            scnt_q <= scnt_q + CNT_W'(1);
        end

        if (to_arm)
          ign_q <= '0;
        else if ((st_q == S_WATCH) && (st_d == S_BRK))
          ign_q <= ign_val;
      end
    end

    assign brk_v[k] = brk_q;
    assign sht_v[k] = sht_q;
    assign opn_v[k] = opn_q;
    assign ev_v[k] = ev_q;
    assign busy_v[k] = busy_q;
    assign ign_v[k*CNT_W +: CNT_W] = ign_q;
  end

endmodule

// File: tb/tb_breakdown_classifier.sv
// Scoreboard bench for breakdown_classifier: two instances,
// one voltage-only, one with current qualification and 4-bit counters.
module tb_breakdown_classifier;

  localparam int HOLD_A = 20;
  localparam int HOLD_B = 5;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] ch;
    logic [7:0] kind;
    logic [31:0] cyc;
    logic [31:0] ign;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  breakdown_classifier_if #(.N_CH(2), .DW(16), .CNT_W(16)) ba();
  breakdown_classifier_if #(.N_CH(2), .DW(16), .CNT_W(4)) bb();

  breakdown_classifier #(
    .N_CH(2), .DW(16), .CNT_W(16),
    .CUR_EN(1'b0), .FILT_N(10),
    .HOLDOFF_CYC(HOLD_A), .TIMEOUT_CYC(100)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ba.slave)
  );

  breakdown_classifier #(
    .N_CH(2), .DW(16), .CNT_W(4),
    .CUR_EN(1'b1), .FILT_N(10),
    .HOLDOFF_CYC(HOLD_B), .TIMEOUT_CYC(0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bb.slave)
  );

  always #5 clk = ~clk;

  function automatic ev_t mk(int d, int c, int k, int t, int g);
    ev_t e;
    e.d = 8'(d);
    e.ch = 8'(c);
    e.kind = 8'(k);
    e.cyc = 32'(t);
    e.ign = 32'(g);
    return e;
  endfunction

  function automatic int kind_of(logic b, logic s, logic o);
    return b ? 1 : s ? 2 : o ? 3 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < 2; c++) begin
      if (ba.event_pulse[c])
        obs_q.push_back(mk(0, c,
          kind_of(ba.is_breakdown[c], ba.is_short[c], ba.is_open[c]),
          cyc, int'(ba.ign_delay[c*16 +: 16])));
      if (bb.event_pulse[c])
        obs_q.push_back(mk(1, c,
          kind_of(bb.is_breakdown[c], bb.is_short[c], bb.is_open[c]),
          cyc, int'(bb.ign_delay[c*4 +: 4])));
    end
  endtask

  task automatic set_smp(int d, int c, int v, int i, bit vld);
    if (d == 0) begin
      ba.sample_voltage[c*16 +: 16] = 16'(v);
      ba.sample_current[c*16 +: 16] = 16'(i);
      ba.sample_valid = vld;
    end else begin
      bb.sample_voltage[c*16 +: 16] = 16'(v);
      bb.sample_current[c*16 +: 16] = 16'(i);
      bb.sample_valid = vld;
    end
  endtask

  task automatic set_arm(int d, int c, bit a);
    if (d == 0) ba.arm[c] = a;
    else bb.arm[c] = a;
  endtask

  task automatic arm_hold(int d, int c);
    set_arm(d, c, 1'b1);
    repeat ((d == 0 ? HOLD_A : HOLD_B) + 1) tick();
  endtask

  task automatic do_clear(int d, int c);
    set_arm(d, c, 1'b0);
    if (d == 0) ba.clear[c] = 1'b1;
    else bb.clear[c] = 1'b1;
    tick();
    if (d == 0) ba.clear[c] = 1'b0;
    else bb.clear[c] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    ba.arm = '0; ba.clear = '0; ba.sample_valid = 1'b0;
    ba.sample_voltage = '0; ba.sample_current = '0;
    bb.arm = '0; bb.clear = '0; bb.sample_valid = 1'b0;
    bb.sample_voltage = '0; bb.sample_current = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    n_chk++;
    if ({ba.is_breakdown, ba.is_short, ba.is_open} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_flags_a got %b want 0",
        {ba.is_breakdown, ba.is_short, ba.is_open});
    end
    n_chk++;
    if ({ba.event_pulse, ba.busy} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_pulse_busy_a got %b want 0",
        {ba.event_pulse, ba.busy});
    end
    n_chk++;
    if (ba.ign_delay !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ign_a got %h want 0", ba.ign_delay);
    end
    n_chk++;
    if ({bb.is_breakdown, bb.is_short, bb.is_open,
         bb.event_pulse, bb.busy, bb.ign_delay} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_all_b got %h want 0",
        {bb.is_breakdown, bb.is_short, bb.is_open,
         bb.event_pulse, bb.busy, bb.ign_delay});
    end
  endtask

  task automatic test_breakdown();
    ev_t e, o;
    arm_hold(0, 0);
    n_chk++;
    if (ba.busy !== 2'b01) begin
      n_fail++;
      $display("FAIL t1_busy got %b want 01", ba.busy);
    end
    for (int j = 0; j < 10; j++) begin
      set_smp(0, 0, 20, 0, 1'b1);
      if (j == 9) exp_q.push_back(mk(0, 0, 1, cyc + 1, 10));
      tick();
    end
    set_smp(0, 0, 20, 0, 1'b0);
    repeat (3) tick();
    n_chk++;
    if ({ba.is_breakdown, ba.is_short, ba.is_open, ba.busy}
        !== 8'b01_00_00_00) begin
      n_fail++;
      $display("FAIL t1_flags got %b want 01000000",
        {ba.is_breakdown, ba.is_short, ba.is_open, ba.busy});
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t1_event_count got %0d want %0d",
          obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL t1_event got %h want %h", o, e);
        end
      end
    end
    do_clear(0, 0);
    n_chk++;
    if ({ba.is_breakdown, ba.busy} !== 4'd0 ||
        ba.ign_delay[15:0] !== 16'd10) begin
      n_fail++;
      $display("FAIL t1_clear got brk=%b busy=%b ign=%0d want 0 0 10",
        ba.is_breakdown, ba.busy, ba.ign_delay[15:0]);
    end
  endtask

  task automatic test_filter_restart();
    ev_t e, o;
    bit vld;
    int v;
    arm_hold(0, 0);
    for (int j = 0; j < 23; j++) begin
      vld = !(j >= 15 && j <= 17);
      v = (j == 9 || !vld) ? 50 : 20;
      set_smp(0, 0, v, 0, vld);
      if (j == 22) exp_q.push_back(mk(0, 0, 1, cyc + 1, 23));
      tick();
    end
    set_smp(0, 0, 0, 0, 1'b0);
    repeat (2) tick();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t2_event_count got %0d want %0d",
          obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL t2_event got %h want %h", o, e);
        end
      end
    end
    do_clear(0, 0);
  endtask

  task automatic test_holdoff();
    ev_t e, o;
    set_arm(0, 1, 1'b1);
    for (int k = 0; k <= HOLD_A + 10; k++) begin
      set_smp(0, 0, 20, 0, 1'b1);
      set_smp(0, 1, 20, 0, 1'b1);
      if (k == HOLD_A + 10)
        exp_q.push_back(mk(0, 1, 1, cyc + 1, 10));
      tick();
    end
    set_smp(0, 1, 0, 0, 1'b0);
    tick();
    n_chk++;
    if (ba.is_breakdown !== 2'b10) begin
      n_fail++;
      $display("FAIL t3_flags got %b want 10", ba.is_breakdown);
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t3_event_count got %0d want %0d",
          obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL t3_event got %h want %h", o, e);
        end
      end
    end
    do_clear(0, 1);
  endtask

  task automatic test_short_rearm();
    ev_t e, o;
    arm_hold(0, 0);
    for (int j = 0; j < 10; j++) begin
      set_smp(0, 0, (j % 2) ? 7 : 2, (j % 2) ? 40 : 60, 1'b1);
      if (j == 9) exp_q.push_back(mk(0, 0, 2, cyc + 1, 0));
      tick();
    end
    set_smp(0, 0, 0, 0, 1'b0);
    repeat (2) tick();
    n_chk++;
    if ({ba.is_breakdown, ba.is_short, ba.is_open} !== 6'b00_01_00) begin
      n_fail++;
      $display("FAIL t4_short_flags got %b want 000100",
        {ba.is_breakdown, ba.is_short, ba.is_open});
    end
    ba.clear[0] = 1'b1;
    tick();
    n_chk++;
    if (ba.busy[0] !== 1'b0 || ba.is_short[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_clear_arm got busy=%b short=%b want 0 0",
        ba.busy[0], ba.is_short[0]);
    end
    ba.clear[0] = 1'b0;
    tick();
    n_chk++;
    if (ba.busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_rearm_busy got %b want 1", ba.busy[0]);
    end
    repeat (HOLD_A) tick();
    for (int j = 0; j < 5; j++) begin
      set_smp(0, 0, 20, 0, 1'b1);
      tick();
    end
    set_arm(0, 0, 1'b0);
    tick();
    n_chk++;
    if (ba.busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_arm_drop got busy=%b want 0", ba.busy[0]);
    end
    repeat (6) tick();
    arm_hold(0, 0);
    for (int j = 0; j < 10; j++) begin
      set_smp(0, 0, 20, 0, 1'b1);
      if (j == 9) exp_q.push_back(mk(0, 0, 1, cyc + 1, 10));
      tick();
    end
    set_smp(0, 0, 0, 0, 1'b0);
    repeat (2) tick();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t4_event_count got %0d want %0d",
          obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL t4_event got %h want %h", o, e);
        end
      end
    end
    do_clear(0, 0);
  endtask

  task automatic test_timeout();
    ev_t e, o;
    arm_hold(0, 0);
    set_smp(0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      if (k == 99) exp_q.push_back(mk(0, 0, 3, cyc + 1, 0));
      tick();
    end
    tick();
    n_chk++;
    if ({ba.is_breakdown[0], ba.is_short[0], ba.is_open[0]} !== 3'b001) begin
      n_fail++;
      $display("FAIL t5_open_flags got %b want 001",
        {ba.is_breakdown[0], ba.is_short[0], ba.is_open[0]});
    end
    do_clear(0, 0);
    arm_hold(0, 0);
    for (int k = 0; k < 100; k++) begin
      set_smp(0, 0, 20, 0, k >= 90);
      if (k == 99) exp_q.push_back(mk(0, 0, 1, cyc + 1, 100));
      tick();
    end
    set_smp(0, 0, 0, 0, 1'b0);
    repeat (3) tick();
    n_chk++;
    if ({ba.is_breakdown[0], ba.is_open[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL t5_brk_wins got %b want 10",
        {ba.is_breakdown[0], ba.is_open[0]});
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t5_event_count got %0d want %0d",
          obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL t5_event got %h want %h", o, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_arm(0, 1, 1'b1);
    set_arm(1, 0, 1'b1);
    repeat (HOLD_A + 1) tick();
    for (int j = 0; j < 3; j++) begin
      set_smp(0, 1, 20, 0, 1'b1);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({ba.busy, ba.is_breakdown, ba.ign_delay} !== 36'd0) begin
      n_fail++;
      $display("FAIL t6_rst_a got busy=%b brk=%b ign=%h want 0",
        ba.busy, ba.is_breakdown, ba.ign_delay);
    end
    n_chk++;
    if (bb.busy !== 2'b00) begin
      n_fail++;
      $display("FAIL t6_rst_b got busy=%b want 00", bb.busy);
    end
    ba.arm = '0;
    bb.arm = '0;
    ba.sample_valid = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    n_chk++;
    if ({ba.busy, ba.is_breakdown, bb.busy} !== 6'd0) begin
      n_fail++;
      $display("FAIL t6_post_rst got %b want 0",
        {ba.busy, ba.is_breakdown, bb.busy});
    end
    exp_q.delete();
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL t6_rst_events got %0d want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_current();
    ev_t e, o;
    int cnt;
    int ign0;
    arm_hold(1, 0);
    cnt = 0;
    for (int s = 0; s < 10; s++) begin
      if (s < 5 && $urandom_range(0, 1) == 1) begin
        set_smp(1, 0, 20, 15, 1'b0);
        tick();
        cnt++;
      end
      set_smp(1, 0, 20, 15, 1'b1);
      if (s == 9) begin
        ign0 = (cnt + 1 > 15) ? 15 : cnt + 1;
        exp_q.push_back(mk(1, 0, 1, cyc + 1, ign0));
      end
      tick();
      cnt++;
    end
    set_smp(1, 0, 0, 0, 1'b0);
    tick();
    arm_hold(1, 1);
    cnt = 0;
    for (int s = 0; s < 21; s++) begin
      if (s < 10) set_smp(1, 1, 20, 5, 1'b1);
      else if (s == 10) set_smp(1, 1, 20, 9, 1'b1);
      else set_smp(1, 1, (s % 2) ? 8 : 35, 10, 1'b1);
      if (s == 20)
        exp_q.push_back(mk(1, 1, 1, cyc + 1, 15));
      tick();
      cnt++;
    end
    set_smp(1, 1, 0, 0, 1'b0);
    repeat (2) tick();
    n_chk++;
    if (bb.is_breakdown !== 2'b11 || bb.ign_delay[7:4] !== 4'd15) begin
      n_fail++;
      $display("FAIL t7_cur got brk=%b ign1=%0d want 11 15",
        bb.is_breakdown, bb.ign_delay[7:4]);
    end
    n_chk++;
    if (bb.ign_delay[3:0] !== 4'(ign0)) begin
      n_fail++;
      $display("FAIL t7_ign0 got %0d want %0d", bb.ign_delay[3:0], ign0);
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_chk++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL t7_event_count got %0d want %0d",
          obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL t7_event got %h want %h", o, e);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_breakdown();
    test_filter_restart();
    test_holdoff();
    test_short_rearm();
    test_timeout();
    test_reset_mid();
    test_current();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
